// File: rtl/maxpool_h2_axis.sv
// Horizontal 2:1 max-pool over an AXI-stream of UNITS signed lanes.
// Pairs consecutive beats within a row, bypasses when en=0, flushes an odd trailing beat at tlast.
module maxpool_h2_axis #(
    parameter int DATA_WIDTH = 16,
    parameter int UNITS      = 2
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        en,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [DATA_WIDTH*UNITS-1:0] s_axis_tdata,
    input  logic                        s_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [DATA_WIDTH*UNITS-1:0] m_axis_tdata,
    output logic                        m_axis_tlast,
    output logic                        dbg_state_o
);

    localparam int W = DATA_WIDTH * UNITS;

    typedef enum logic {
        ST_EVEN = 1'b0,
        ST_ODD  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           mode_q, mode_d;
    logic [W-1:0]   hold_q, hold_d;
    logic           m_valid_q, m_valid_d;
    logic [W-1:0]   m_data_q, m_data_d;
    logic           m_last_q, m_last_d;

    logic           accept;
    logic           mode_eff;
    logic           produce;
    logic [W-1:0]   out_data;
    logic [W-1:0]   max_data;

    // Valid/ready: a beat moves on a channel only when valid and ready are both high
    // on a rising edge; tready depends only on the output register and m_axis_tready.
    assign s_axis_tready = !m_valid_q || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;
    assign dbg_state_o   = (state_q == ST_ODD);

    always_comb begin
        max_data = '0;
        for (int i = 0; i < UNITS; i++) begin
            if ($signed(hold_q[i*DATA_WIDTH +: DATA_WIDTH]) >
                $signed(s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]))
                max_data[i*DATA_WIDTH +: DATA_WIDTH] = hold_q[i*DATA_WIDTH +: DATA_WIDTH];
            else
                max_data[i*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        hold_d    = hold_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        produce   = 1'b0;
        out_data  = s_axis_tdata;
        // Between pairs en acts immediately; mid-pair the latched mode is kept.
        mode_eff  = (state_q == ST_EVEN) ? en : mode_q;

        if (state_q == ST_EVEN)
            mode_d = en;

        if (accept) begin
            case (state_q)
                ST_EVEN: begin
                    if (!mode_eff || s_axis_tlast) begin
                        produce = 1'b1;
                    end else begin
                        hold_d  = s_axis_tdata;
                        state_d = ST_ODD;
                    end
                end
                ST_ODD: begin
                    produce  = 1'b1;
                    out_data = max_data;
                    state_d  = ST_EVEN;
                end
                default: state_d = ST_EVEN;
            endcase
        end

        if (produce) begin
            m_valid_d = 1'b1;
            m_data_d  = out_data;
            m_last_d  = s_axis_tlast;
        end else if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= ST_EVEN;
            mode_q    <= 1'b1;
            hold_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            hold_q    <= hold_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

endmodule
